// File: rtl/cpu_pkg.sv
// Shared core parameters and helpers.
// Used by operand fetch and the register file.
package cpu_pkg;

    localparam int DATABUS_SIZE      = 24;
    localparam int REGFILE_ADDR_BITS = 4;
    localparam int REGFILE_NUM_REGS  = 16;
    localparam int CTRL_BITS         = 8;

    typedef logic [DATABUS_SIZE-1:0]      data_t;
    typedef logic [REGFILE_ADDR_BITS-1:0] reg_idx_t;
    typedef logic [CTRL_BITS-1:0]         ctrl_t;

    // R0 is hardwired zero; a same-cycle writeback beats the register file.
    function automatic data_t bypass(
        input reg_idx_t idx,
        input data_t    rf_data,
        input logic     wb_we,
        input reg_idx_t wb_addr,
        input data_t    wb_data
    );
        if (idx == '0)
            return '0;
        else if (wb_we && wb_addr == idx)
            return wb_data;
        else
            return rf_data;
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Per-register busy bits with set/clear and three
// writeback-aware hazard query ports.
module operand_scoreboard
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t q_idx1,
    input  reg_idx_t q_idx2,
    input  reg_idx_t q_idx3,
    output logic     q_busy1,
    output logic     q_busy2,
    output logic     q_busy3
);

    logic [REGFILE_NUM_REGS-1:0] busy;

    // Set has priority so a new writer survives a retiring one.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < REGFILE_NUM_REGS; r++) begin
                if (set_en && set_idx == reg_idx_t'(r))
                    busy[r] <= 1'b1;
                else if (clr_en && clr_idx == reg_idx_t'(r))
                    busy[r] <= 1'b0;
            end
            busy[0] <= 1'b0;
        end
    end

    function automatic logic src_busy(input reg_idx_t idx);
        return busy[idx] && !(clr_en && clr_idx == idx);
    endfunction

    assign q_busy1 = src_busy(q_idx1);
    assign q_busy2 = src_busy(q_idx2);
    assign q_busy3 = src_busy(q_idx3);

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: regfile read, writeback bypass,
// scoreboard interlock and one-entry output register.
module operand_fetch
    import cpu_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [REGFILE_ADDR_BITS-1:0] in_rs1,
    input  logic [REGFILE_ADDR_BITS-1:0] in_rs2,
    input  logic [REGFILE_ADDR_BITS-1:0] in_rd,
    input  logic                         in_rd_we,
    input  logic [CTRL_BITS-1:0]         in_ctrl,
    output logic [REGFILE_ADDR_BITS-1:0] rf_read_addr1,
    output logic [REGFILE_ADDR_BITS-1:0] rf_read_addr2,
    input  logic [DATABUS_SIZE-1:0]      rf_read_data1,
    input  logic [DATABUS_SIZE-1:0]      rf_read_data2,
    input  logic                         wb_write_enable,
    input  logic [REGFILE_ADDR_BITS-1:0] wb_write_addr,
    input  logic [DATABUS_SIZE-1:0]      wb_write_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATABUS_SIZE-1:0]      out_op1,
    output logic [DATABUS_SIZE-1:0]      out_op2,
    output logic [REGFILE_ADDR_BITS-1:0] out_rd,
    output logic                         out_rd_we,
    output logic [CTRL_BITS-1:0]         out_ctrl,
    output logic [15:0]                  stall_cycles
);

    logic  busy_rs1, busy_rs2, busy_rd;
    logic  hazard, slot_free, accept;
    data_t op1, op2;

    assign rf_read_addr1 = in_rs1;
    assign rf_read_addr2 = in_rs2;

    operand_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (accept && in_rd_we && in_rd != '0),
        .set_idx (in_rd),
        .clr_en  (wb_write_enable && wb_write_addr != '0),
        .clr_idx (wb_write_addr),
        .q_idx1  (in_rs1),
        .q_idx2  (in_rs2),
        .q_idx3  (in_rd),
        .q_busy1 (busy_rs1),
        .q_busy2 (busy_rs2),
        .q_busy3 (busy_rd)
    );

    assign hazard    = busy_rs1 || busy_rs2 || (in_rd_we && busy_rd);
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && !hazard;
    assign accept    = in_valid && in_ready;

    assign op1 = bypass(in_rs1, rf_read_data1, wb_write_enable,
                        wb_write_addr, wb_write_data);
    assign op2 = bypass(in_rs2, rf_read_data2, wb_write_enable,
                        wb_write_addr, wb_write_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            out_ctrl  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op1   <= op1;
            out_op2   <= op2;
            out_rd    <= in_rd;
            out_rd_we <= in_rd_we;
            out_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (in_valid && !in_ready && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
    end

endmodule
